// File: rtl/ex_store_buffer.sv
// Store buffer between execute and the data bus: in-order drain, optional coalescing, byte-granular load forwarding.
// Latency: a push is visible on the bus and to lookups one cycle later; lookups are combinational on current state.
// Backpressure: push_ready drops when all entries are valid; the head stays stable on the bus until bus_ack.
module ex_store_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int MERGE  = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push_valid,
    output logic                         push_ready,
    input  logic [ADDR_W-1:0]            push_addr,
    input  logic [DATA_W-1:0]            push_wdata,
    input  logic [DATA_W/8-1:0]          push_strb,
    input  logic                         ld_valid,
    input  logic [ADDR_W-1:0]            ld_addr,
    input  logic [DATA_W/8-1:0]          ld_strb,
    output logic [DATA_W-1:0]            ld_fwd_data,
    output logic [DATA_W/8-1:0]          ld_fwd_strb,
    output logic                         ld_conflict,
    output logic                         bus_req,
    output logic [ADDR_W-1:0]            bus_addr,
    output logic [DATA_W-1:0]            bus_wdata,
    output logic [DATA_W/8-1:0]          bus_strb,
    input  logic                         bus_ack,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int SW = DATA_W / 8;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [SW-1:0]     strb_q [DEPTH];
    logic [DEPTH-1:0]  valid_q;
    logic [PW-1:0]     head, tail, ytail, fwd_idx;
    logic              push_acc, do_merge, new_push, pop;
    logic [SW-1:0]     hit_strb;
    logic [DATA_W-1:0] hit_data;
    logic [ADDR_W-1:0] push_word;

    function automatic logic [ADDR_W-1:0] word_of(input logic [ADDR_W-1:0] a);
        return a & ~ADDR_W'(SW - 1);
    endfunction

    assign empty      = (count == '0);
    assign push_ready = (count != CW'(DEPTH));
    assign bus_req    = !empty;
    assign bus_addr   = addr_q[head];
    assign bus_wdata  = data_q[head];
    assign bus_strb   = strb_q[head];

    assign push_word = word_of(push_addr);
    assign ytail     = tail - PW'(1);
    assign push_acc  = push_valid && push_ready && (push_strb != '0);
    // With two or more entries the youngest is never the head, so it can be rewritten
    // without disturbing what the bus currently sees.
    assign do_merge  = (MERGE != 0) && push_acc && (count >= CW'(2)) && (addr_q[ytail] == push_word);
    assign new_push  = push_acc && !do_merge;
    assign pop       = bus_ack && bus_req;

    always_ff @(posedge clk) begin
        if (rst) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            valid_q <= '0;
        end else begin
            if (pop) begin
                valid_q[head] <= 1'b0;
                head          <= head + PW'(1);
            end
            if (new_push) begin
                addr_q[tail]  <= push_word;
                data_q[tail]  <= push_wdata;
                strb_q[tail]  <= push_strb;
                valid_q[tail] <= 1'b1;
                tail          <= tail + PW'(1);
            end
            if (do_merge) begin
                for (int i = 0; i < SW; i++) begin
                    if (push_strb[i]) data_q[ytail][8*i +: 8] <= push_wdata[8*i +: 8];
                end
                strb_q[ytail] <= strb_q[ytail] | push_strb;
            end
            case ({new_push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Walk from oldest to youngest so later matches override earlier ones per lane.
    always_comb begin
        hit_strb    = '0;
        hit_data    = '0;
        fwd_idx     = '0;
        ld_fwd_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            fwd_idx = head + PW'(k);
            if (valid_q[fwd_idx] && (addr_q[fwd_idx] == word_of(ld_addr))) begin
                for (int i = 0; i < SW; i++) begin
                    if (strb_q[fwd_idx][i]) begin
                        hit_strb[i]          = 1'b1;
                        hit_data[8*i +: 8]   = data_q[fwd_idx][8*i +: 8];
                    end
                end
            end
        end
        ld_fwd_strb = ld_valid ? (hit_strb & ld_strb) : '0;
        for (int i = 0; i < SW; i++) begin
            if (ld_fwd_strb[i]) ld_fwd_data[8*i +: 8] = hit_data[8*i +: 8];
        end
        ld_conflict = ld_valid && (ld_fwd_strb != '0) && (ld_fwd_strb != ld_strb);
    end
endmodule
